// File: rtl/lifo_stack.sv
// Synchronous LIFO stack (operator stack of the infix-to-postfix converter) with a combinational top peek.
// Optional macro STACK_EMPTY_X_EN: peek drives all-X instead of all-zero while empty.
module lifo_stack #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 20,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_stb_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_stb_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             empty;
  logic             full;
  logic [CW-1:0]    top_idx;
  logic [WIDTH-1:0] top_dat;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign top_idx = count_q - CW'(1);

  // Mux the top entry; top_idx wraps when empty, which the empty override masks.
  always_comb begin
    top_dat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (top_idx == CW'(i)) top_dat = mem_q[i];
    end
  end

`ifdef STACK_EMPTY_X_EN
  assign pop_dat_o = empty ? {WIDTH{1'bx}} : top_dat;
`else
  assign pop_dat_o = empty ? '0 : top_dat;
`endif

  assign empty_o     = empty;
  assign full_o      = full;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    unique case ({push_stb_i, pop_stb_i})
      2'b10: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i)) mem_d[i] = push_dat_i;
          end
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty) unf_d = 1'b1;
        else       count_d = count_q - CW'(1);
      end
      2'b11: begin
        // Simultaneous push/pop replaces the top; on an empty stack it degrades to a push.
        if (empty) begin
          mem_d[0] = push_dat_i;
          count_d  = CW'(1);
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (top_idx == CW'(i)) mem_d[i] = push_dat_i;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: queue-based reference model, per-cycle compare, scripted and random stimulus.
module tb_lifo_stack;
  localparam int W  = 3;
  localparam int D  = 20;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push_stb = 1'b0;
  logic [W-1:0]  push_dat = '0;
  logic          pop_stb = 1'b0;
  logic [W-1:0]  pop_dat;
  logic          empty, full, overflow, underflow;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  lifo_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_stb_i(push_stb), .push_dat_i(push_dat), .pop_stb_i(pop_stb),
    .pop_dat_o(pop_dat), .empty_o(empty), .full_o(full), .count_o(count),
    .overflow_o(overflow), .underflow_o(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue whose back is the top of stack.
  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (push_stb && pop_stb) begin
        if (mq.size() == 0) mq.push_back(push_dat);
        else mq[mq.size()-1] = push_dat;
      end else if (push_stb) begin
        if (mq.size() == D) m_ovf = 1'b1;
        else mq.push_back(push_dat);
      end else if (pop_stb) begin
        if (mq.size() == 0) m_unf = 1'b1;
        else void'(mq.pop_back());
      end
    end
  end

  function automatic logic [W-1:0] model_top();
`ifdef STACK_EMPTY_X_EN
    if (mq.size() == 0) return {W{1'bx}};
`else
    if (mq.size() == 0) return '0;
`endif
    return mq[mq.size()-1];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_count", 32'(count), 32'(mq.size()));
    check("cmp_empty", 32'(empty), 32'(mq.size() == 0));
    check("cmp_full", 32'(full), 32'(mq.size() == D));
    check("cmp_pop_dat", {{(32-W){1'b0}}, pop_dat}, {{(32-W){1'b0}}, model_top()});
    check("cmp_overflow", 32'(overflow), 32'(m_ovf));
    check("cmp_underflow", 32'(underflow), 32'(m_unf));
  end

  // Drive one cycle of strobes; returns 1 time unit after the edge that consumed them.
  task automatic op(input logic ps, input logic [W-1:0] pd, input logic pp);
    push_stb = ps; push_dat = pd; pop_stb = pp;
    @(posedge clk); #1;
    push_stb = 1'b0; push_dat = '0; pop_stb = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [W-1:0] empty_val;

  initial begin
`ifdef STACK_EMPTY_X_EN
    empty_val = {W{1'bx}};
`else
    empty_val = '0;
`endif
    @(posedge clk); #1;
    do_reset();
    op(1'b0, '0, 1'b0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pop_dat", 32'(pop_dat), 32'(empty_val));
    check("rst_flags", 32'({overflow, underflow}), 32'd0);

    op(1'b1, 3'b001, 1'b0); check("push1", 32'(pop_dat), 32'd1);
    op(1'b1, 3'b010, 1'b0); check("push2", 32'(pop_dat), 32'd2);
    op(1'b1, 3'b011, 1'b0); check("push3", 32'(pop_dat), 32'd3);
    check("push3_count", 32'(count), 32'd3);
    op(1'b0, '0, 1'b1); check("pop1", 32'(pop_dat), 32'd2);
    op(1'b0, '0, 1'b1); check("pop2", 32'(pop_dat), 32'd1);
    op(1'b0, '0, 1'b1); check("pop3_empty", 32'(empty), 32'd1);
    check("pop3_dat", 32'(pop_dat), 32'(empty_val));

    for (int i = 0; i < D; i++) op(1'b1, W'(i % 8), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd20);
    check("fill_top", 32'(pop_dat), 32'd3);
    op(1'b1, 3'b111, 1'b0);
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd20);
    check("ovf_top", 32'(pop_dat), 32'd3);
    op(1'b0, '0, 1'b0);
    check("ovf_clear", 32'(overflow), 32'd0);
    op(1'b1, 3'b110, 1'b1);
    check("full_replace_top", 32'(pop_dat), 32'd6);
    check("full_replace_cnt", 32'(count), 32'd20);

    do_reset();
    op(1'b0, '0, 1'b1);
    check("unf_pulse", 32'(underflow), 32'd1);
    check("unf_count", 32'(count), 32'd0);
    op(1'b1, 3'b100, 1'b1);
    check("pp_empty_count", 32'(count), 32'd1);
    check("pp_empty_dat", 32'(pop_dat), 32'd4);
    check("pp_empty_unf", 32'(underflow), 32'd0);
    op(1'b0, '0, 1'b1);

    op(1'b1, 3'b001, 1'b0);
    op(1'b1, 3'b010, 1'b0);
    op(1'b1, 3'b011, 1'b1);
    check("replace_count", 32'(count), 32'd2);
    check("replace_dat", 32'(pop_dat), 32'd3);
    op(1'b0, '0, 1'b1);
    check("replace_pop", 32'(pop_dat), 32'd1);

    for (int i = 0; i < 5; i++) op(1'b1, W'(i + 1), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random phase: push-heavy and pop-heavy windows so both boundaries get exercised.
    for (int i = 0; i < 3000; i++) begin
      int r, bias;
      bias = ((i / 200) % 2 == 0) ? 65 : 30;
      r = $urandom_range(99);
      if (i % 997 == 500) begin
        #3 rst_n = 1'b0;
        #1;
        check("rnd_async_rst", 32'(count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else if (r < 10) begin
        op(1'b1, W'($urandom), 1'b1);
      end else if (r < 10 + bias) begin
        op(1'b1, W'($urandom), 1'b0);
      end else if (r < 95) begin
        op(1'b0, '0, 1'b1);
      end else begin
        op(1'b0, '0, 1'b0);
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parameterised synchronous LIFO stack holding up to DEPTH entries of WIDTH bits, with the top entry continuously visible on a combinational peek output. It serves as the operator stack of the infix-to-postfix expression converter: default 3-bit operator codes, 20 entries deep. Push and pop are single-cycle strobes sampled on the rising clock edge. Status outputs report empty, full, occupancy and overflow/underflow errors.

## Interface
- WIDTH, default 3: bits per entry (≥1).
- DEPTH, default 20: maximum number of entries (≥2).
- CW: localparam, $clog2(DEPTH+1); width of COUNT.
- CLK  input  1: clock; all state updates on the rising edge.
- RST_N  input  1: reset, asynchronous, active-low.
- PUSH_STB  input  1: push PUSH_DAT this cycle.
- PUSH_DAT  input  WIDTH: data to push.
- POP_STB  input  1: remove the top entry this cycle.
- POP_DAT  output  WIDTH: combinational peek of the current top entry; empty value when COUNT==0.
- EMPTY  output  1: COUNT==0.
- FULL  output  1: COUNT==DEPTH.
- COUNT  output  CW: current occupancy, 0..DEPTH.
- OVERFLOW  output  1: registered one-cycle pulse; a push was dropped.
- UNDERFLOW  output  1: registered one-cycle pulse; a pop was dropped.

## Operation
- Storage: DEPTH×WIDTH register array plus an occupancy counter/pointer; the top entry is mem[COUNT-1].
- Strobes are level-sampled every edge. Each cycle a strobe is high performs one operation. Callers hold a strobe for exactly one cycle per operation.
- Push only:
  - not full: mem[COUNT]←PUSH_DAT, COUNT+1.
  - full: no change, OVERFLOW=1 next cycle.
- Pop only:
  - not empty: COUNT-1; the popped data is the POP_DAT value shown before the edge.
  - empty: no change, UNDERFLOW=1 next cycle.
- Push and pop together:
  - not empty, including full: replace top, mem[COUNT-1]←PUSH_DAT, COUNT unchanged, no error.
  - empty: plain push, COUNT→1, no UNDERFLOW.
- Neither strobe: hold all state. OVERFLOW/UNDERFLOW return to 0.
- POP_DAT, EMPTY and FULL derive combinationally from COUNT and the array. There is no read strobe.

## Timing
- Reset (RST_N low, asynchronous): COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, UNDERFLOW=0, POP_DAT=empty value, array cleared to 0.
- Reset mid-operation discards all contents immediately. The first edge after RST_N rises may push.
- Latency: a push at edge N appears on POP_DAT after edge N, so it is readable in cycle N+1. A pop at edge N exposes the next-lower entry in cycle N+1.
- Back-to-back operations are supported every cycle, with no bubble.
- Error pulses assert exactly in the cycle after the dropped operation and last one cycle. They repeat each cycle the illegal strobe persists.

## Configuration
- STACK_EMPTY_X_EN defined: when empty, POP_DAT drives all-X ({WIDTH{1'bx}}), so consumers can detect empty with ===x. Simulation-compatibility mode.
- STACK_EMPTY_X_EN undefined (default, synthesis): when empty, POP_DAT drives all-zero. Consumers use EMPTY.
- No other behaviour differs.

## Test plan
- Reset then idle -> EMPTY=1, COUNT=0, POP_DAT=0 (or X with STACK_EMPTY_X_EN), both error flags 0.
- Push 3'b001, then 3'b010, then 3'b011 on consecutive cycles -> POP_DAT 1,2,3 in the following cycles. Then pop ×3 -> POP_DAT 2,1, then empty, EMPTY=1.
- Push 20 values 0..19 mod 8 -> FULL=1, COUNT=20. A 21st push -> OVERFLOW pulse for 1 cycle, COUNT stays 20, top unchanged.
- Pop while empty -> UNDERFLOW pulse, COUNT stays 0. Push+pop while empty with 3'b100 -> COUNT=1, POP_DAT=3'b100.
- With stack [1,2], push 3'b011 and pop in the same cycle -> COUNT=2, POP_DAT=3. Pop -> POP_DAT=1.
- Push 5 entries, assert RST_N low between edges -> COUNT=0 and EMPTY=1 immediately, before the next clock edge.
